// File: rtl/ocr_template_matcher.sv
// Template-matching sequencer for the OCR digit memory: sweeps every template/pixel,
// accumulates per-template SAD and reports the lowest-scoring digit with a done pulse.
module ocr_template_matcher #(
    parameter int NUM_TEMPLATES = 10,
    parameter int PIXELS        = 256,
    parameter int PIX_W         = 8,
    parameter int ADDR_W        = 4,
    parameter int CNT_W         = 8,
    parameter int SCORE_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ip_start,
    input  logic [PIX_W-1:0]   ip_pixA,
    input  logic [PIX_W-1:0]   ip_pixT,
    output logic [ADDR_W-1:0]  op_address,
    output logic [CNT_W-1:0]   op_count,
    output logic               op_busy,
    output logic               op_done,
    output logic [ADDR_W-1:0]  op_digit,
    output logic [SCORE_W-1:0] op_score
);

    // state | meaning
    // IDLE  | waiting for ip_start, address/count parked at 0
    // SCAN  | streaming pixels of template tpl, one per cycle
    // TAIL  | folding the last pixel's difference into acc
    // CMP   | comparing acc against best, advancing to next template
    // DONE  | one-cycle result-valid pulse
    typedef enum logic [2:0] {IDLE, SCAN, TAIL, CMP, DONE} state_t;

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PIXELS - 1);
    localparam logic [ADDR_W-1:0] LAST_TPL = ADDR_W'(NUM_TEMPLATES - 1);

    state_t               state;
    state_t               state_next;
    logic [ADDR_W-1:0]    tpl;
    logic [CNT_W-1:0]     cnt;
    logic [PIX_W-1:0]     diff;
    logic [PIX_W-1:0]     abs_diff;
    logic [SCORE_W-1:0]   acc;
    logic [SCORE_W-1:0]   best;
    logic [ADDR_W-1:0]    best_idx;
    logic                 better;

    assign abs_diff   = (ip_pixA > ip_pixT) ? (ip_pixA - ip_pixT) : (ip_pixT - ip_pixA);
    assign better     = (acc < best);
    assign op_address = tpl;
    assign op_count   = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        op_busy    = 1'b1;
        op_done    = 1'b0;
        case (state)
            IDLE: begin
                op_busy = 1'b0;
                if (ip_start) state_next = SCAN;
            end
            SCAN: if (cnt == LAST_CNT) state_next = TAIL;
            TAIL: state_next = CMP;
            CMP:  state_next = (tpl == LAST_TPL) ? DONE : SCAN;
            DONE: begin
                op_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers load on the CMP->DONE edge so they are valid during the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tpl      <= '0;
            cnt      <= '0;
            diff     <= '0;
            acc      <= '0;
            best     <= '1;
            best_idx <= '0;
            op_digit <= '0;
            op_score <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ip_start) begin
                        tpl      <= '0;
                        cnt      <= '0;
                        diff     <= '0;
                        acc      <= '0;
                        best     <= '1;
                        best_idx <= '0;
                    end
                end
                SCAN: begin
                    diff <= abs_diff;
                    acc  <= acc + SCORE_W'(diff);
                    cnt  <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
                end
                TAIL: acc <= acc + SCORE_W'(diff);
                CMP: begin
                    if (better) begin
                        best     <= acc;
                        best_idx <= tpl;
                    end
                    acc  <= '0;
                    diff <= '0;
                    if (tpl == LAST_TPL) begin
                        op_digit <= better ? tpl : best_idx;
                        op_score <= better ? acc : best;
                        tpl      <= '0;
                    end else begin
                        tpl <= tpl + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ocr_template_matcher.sv
// Scoreboard bench for ocr_template_matcher: a behavioural pixel memory feeds the DUT,
// expected digit/score are computed from the same memory contents and queued per start.
module tb_ocr_template_matcher;

    localparam int NT      = 10;
    localparam int NP      = 256;
    localparam int LATENCY = NT * (NP + 2);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ip_start = 1'b0;
    logic [7:0]  ip_pixA;
    logic [7:0]  ip_pixT;
    logic [3:0]  op_address;
    logic [7:0]  op_count;
    logic        op_busy;
    logic        op_done;
    logic [3:0]  op_digit;
    logic [15:0] op_score;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;
    int range_err = 0;
    int exp_digit_q[$];
    int exp_score_q[$];

    ocr_template_matcher dut (
        .clk(clk), .rst(rst), .ip_start(ip_start),
        .ip_pixA(ip_pixA), .ip_pixT(ip_pixT),
        .op_address(op_address), .op_count(op_count),
        .op_busy(op_busy), .op_done(op_done),
        .op_digit(op_digit), .op_score(op_score)
    );

    always #5 clk = ~clk;

    function automatic int model_t(input int m, input int c);
        case (m)
            0:       return 80;
            1:       return (c * 7) & 255;
            2:       return 0;
            default: return (c * 29 + 11) & 255;
        endcase
    endfunction

    function automatic int model_a(input int m, input int a, input int c);
        int t;
        t = model_t(m, c);
        case (m)
            0:       return (a * 20) & 255;
            1:       return (a == 7) ? t : ((t == 255) ? 254 : t + 1);
            2:       return 255;
            default: return ((a * 37 + c * 13) ^ (c >> 1)) & 255;
        endcase
    endfunction

    always_comb begin
        ip_pixA = 8'(model_a(mode, int'(op_address), int'(op_count)));
        ip_pixT = 8'(model_t(mode, int'(op_count)));
    end

    always @(negedge clk) begin
        if (!rst && (int'(op_address) >= NT)) range_err++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input int m);
        int best_s, best_d, s, a, t;
        best_s = 65535;
        best_d = 0;
        for (int k = 0; k < NT; k++) begin
            s = 0;
            for (int c = 0; c < NP; c++) begin
                a = model_a(m, k, c);
                t = model_t(m, c);
                s += (a > t) ? a - t : t - a;
            end
            if (s < best_s) begin
                best_s = s;
                best_d = k;
            end
        end
        exp_digit_q.push_back(best_d);
        exp_score_q.push_back(best_s);
    endtask

    // k counts clock edges after the accepting edge; template t occupies k = 258t .. 258t+257.
    task automatic do_run(input int m, input bit poke);
        int k, perr, busy_low, d_exp, s_exp, held_d;
        mode = m;
        push_expected(m);
        @(negedge clk) ip_start = 1'b1;
        @(negedge clk) ip_start = 1'b0;
        k = 0; perr = 0; busy_low = 0;
        while (k <= LATENCY + 400) begin
            if (k < LATENCY && (k % (NP + 2)) < NP &&
                (int'(op_address) != k / (NP + 2) || int'(op_count) != k % (NP + 2)))
                perr++;
            if (!op_busy) busy_low++;
            if (op_done) break;
            @(negedge clk);
            k++;
            ip_start = poke && (k == 5 || k == 1000);
        end
        check($sformatf("latency_m%0d", m), k, LATENCY);
        d_exp = exp_digit_q.pop_front();
        s_exp = exp_score_q.pop_front();
        check($sformatf("digit_m%0d", m), int'(op_digit), d_exp);
        check($sformatf("score_m%0d", m), int'(op_score), s_exp);
        check($sformatf("pair_order_m%0d", m), perr, 0);
        check($sformatf("busy_low_m%0d", m), busy_low, 0);
        held_d = int'(op_digit);
        ip_start = poke;
        @(negedge clk) ip_start = 1'b0;
        check($sformatf("done_width_m%0d", m), int'(op_done), 0);
        check($sformatf("digit_hold_m%0d", m), int'(op_digit), d_exp);
        check($sformatf("score_hold_m%0d", m), int'(op_score), s_exp);
        @(negedge clk);
        check($sformatf("no_restart_m%0d", m), int'(op_busy), 0);
        if (held_d != d_exp) ; // already reported by digit check
    endtask

    task automatic abort_run(input int m, input int at_cycle);
        int dones;
        mode = m;
        push_expected(m);
        @(negedge clk) ip_start = 1'b1;
        @(negedge clk) ip_start = 1'b0;
        dones = 0;
        for (int k = 0; k < at_cycle; k++) begin
            if (op_done) dones++;
            @(negedge clk);
        end
        check("busy_before_abort", int'(op_busy), 1);
        check("addr_before_abort", int'(op_address), at_cycle / (NP + 2));
        #2 rst = 1'b1;
        #1;
        void'(exp_digit_q.pop_back());
        void'(exp_score_q.pop_back());
        check("abort_no_done", dones, 0);
        check("abort_busy", int'(op_busy), 0);
        check("abort_done", int'(op_done), 0);
        check("abort_addr", int'(op_address), 0);
        check("abort_count", int'(op_count), 0);
        check("abort_digit", int'(op_digit), 0);
        check("abort_score", int'(op_score), 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("abort_idle", int'(op_busy), 0);
    endtask

    initial begin
        #1;
        check("rst_busy", int'(op_busy), 0);
        check("rst_done", int'(op_done), 0);
        check("rst_addr", int'(op_address), 0);
        check("rst_count", int'(op_count), 0);
        check("rst_digit", int'(op_digit), 0);
        check("rst_score", int'(op_score), 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("idle_without_start", int'(op_busy), 0);

        do_run(0, 1'b0);
        do_run(1, 1'b1);
        do_run(3, 1'b0);
        do_run(2, 1'b0);
        abort_run(0, 1200);
        do_run(0, 1'b0);
        do_run(1, 1'b0);

        check("scoreboard_empty", exp_digit_q.size(), 0);
        check("addr_range", range_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
